// File: rtl/spi_shift_unit_pkg.sv
// -----------------------------------------------------------------------------
// Isa: shared definitions for the serial processor's shift/rotate slave.
//   ShiftOp  - 3-bit opcode encoding; codes 5..7 are undefined.
//   amt_bits - width of the shift-amount field for a given operand width.
//   in_len   - request packet length in bits (op + operand + amount).
//   out_len  - response frame length in bits (result + zero + error).
// -----------------------------------------------------------------------------
package Isa;

   typedef enum logic [2:0] {
      ROL = 3'd0,
      ROR = 3'd1,
      SLL = 3'd2,
      SRL = 3'd3,
      SRA = 3'd4
   } ShiftOp;

   function automatic int amt_bits(input int width);
      return $clog2(width);
   endfunction

   function automatic int in_len(input int width);
      return 3 + width + $clog2(width);
   endfunction

   function automatic int out_len(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/spi_shift_unit_if.sv
// -----------------------------------------------------------------------------
// Spi: shared SPI bus bundle.
//   nss  - one active-low select line per slave.
//   mosi - master to slave data.
//   miso - slave to master data; a slave releases it (Z) when not selected.
// -----------------------------------------------------------------------------
interface Spi #(
   parameter int NssWidth = 1
);
   logic [NssWidth-1:0] nss;
   logic                mosi;
   logic                miso;

   modport SlaveSpi  (input  nss, input  mosi, output miso);
   modport MasterSpi (output nss, output mosi, input  miso);
endinterface

// File: rtl/spi_shift_unit_shift_core.sv
// -----------------------------------------------------------------------------
// shift_core: combinational shift/rotate datapath.
//   i_op      - opcode (ShiftOp encoding; 5..7 undefined)
//   i_operand - Width-bit operand
//   i_amount  - unsigned shift amount, always < Width
//   o_result  - shifted/rotated operand, 0 for undefined opcodes
//   o_zero    - result is zero for a defined opcode
//   o_error   - opcode undefined
// -----------------------------------------------------------------------------
module shift_core
   import Isa::*;
#(
   parameter  int Width   = 8,
   localparam int AmtBits = $clog2(Width)
) (
   input  logic [2:0]         i_op,
   input  logic [Width-1:0]   i_operand,
   input  logic [AmtBits-1:0] i_amount,
   output logic [Width-1:0]   o_result,
   output logic               o_zero,
   output logic               o_error
);

   // Rotates are taken from a doubled operand so bits shifted out of one copy
   // come back in from the other.
   logic [2*Width-1:0] doubled;
   logic [2*Width-1:0] rol_wide;
   logic [2*Width-1:0] ror_wide;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      doubled  = {i_operand, i_operand};
      rol_wide = doubled << i_amount;
      ror_wide = doubled >> i_amount;
      o_result = '0;
      o_error  = 1'b0;
      case (i_op)
         ROL:     o_result = rol_wide[2*Width-1:Width];
         ROR:     o_result = ror_wide[Width-1:0];
         SLL:     o_result = i_operand << i_amount;
         SRL:     o_result = i_operand >> i_amount;
         SRA:     o_result = Width'($signed(i_operand) >>> i_amount);
         default: o_error  = 1'b1;
      endcase
      o_zero = ~o_error & (o_result == '0);
   end

endmodule

// File: rtl/spi_shift_unit.sv
// -----------------------------------------------------------------------------
// spi_shift_unit: SPI slave wrapping the shift/rotate datapath.
//   i_clock - system clock, all state changes on the rising edge
//   i_reset - synchronous active-high reset
//   spi     - SlaveSpi modport: reads nss[NssPosition] and mosi, drives miso
// A start bit (mosi=1) opens a request packet {amount, operand, op}, LSB
// first. After one compute cycle the unit holds miso=1 until the master acks
// with mosi=0, then returns {error, zero, result}, LSB first. Deselecting
// mid-packet or mid-frame abandons the transfer.
// -----------------------------------------------------------------------------
module spi_shift_unit
   import Isa::*;
#(
   parameter int NssPosition = 0,
   parameter int Width       = 8
) (
   input logic  i_clock,
   input logic  i_reset,
   Spi.SlaveSpi spi
);

   localparam int AmtBits = amt_bits(Width);
   localparam int InLen   = in_len(Width);
   localparam int OutLen  = out_len(Width);
   localparam int CntBits = $clog2(InLen);

   typedef enum logic [2:0] {
      IDLE,
      RECEIVING,
      OPERATE,
      READY,
      SENDING
   } state_e;

   state_e             state_q, state_d;
   logic [CntBits-1:0] cnt_q, cnt_d;
   logic [InLen-1:0]   in_q, in_d;
   logic [OutLen-1:0]  frame_q, frame_d;

   logic               selected;
   logic               miso_bit;
   logic [Width-1:0]   core_result;
   logic               core_zero;
   logic               core_error;

   assign selected = ~spi.nss[NssPosition];

   shift_core #(.Width(Width)) u_core (
      .i_op      (in_q[2:0]),
      .i_operand (in_q[3 +: Width]),
      .i_amount  (in_q[3 + Width +: AmtBits]),
      .o_result  (core_result),
      .o_zero    (core_zero),
      .o_error   (core_error)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_d     = in_q;
      frame_d  = frame_q;
      miso_bit = 1'b0;
      case (state_q)
         IDLE: begin
            if (selected && spi.mosi) state_d = RECEIVING;
         end
         RECEIVING: begin
            // Bits arrive LSB first, so shifting in from the top leaves the
            // first bit at position 0 once the packet is complete.
            in_d  = {spi.mosi, in_q[InLen-1:1]};
            cnt_d = cnt_q + 1'b1;
            // Completion is checked before deselect so a final bit that
            // coincides with deselect still finishes the packet.
            if (cnt_q == CntBits'(InLen - 1)) begin
               state_d = OPERATE;
               cnt_d   = '0;
            end else if (!selected) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         OPERATE: begin
            frame_d = {core_error, core_zero, core_result};
            state_d = READY;
         end
         READY: begin
            miso_bit = 1'b1;
            if (selected && !spi.mosi) state_d = SENDING;
         end
         SENDING: begin
            miso_bit = frame_q[0];
            frame_d  = {1'b0, frame_q[OutLen-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntBits'(OutLen - 1) || !selected) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign spi.miso = selected ? miso_bit : 1'bz;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         in_q    <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         in_q    <= in_d;
         frame_q <= frame_d;
      end
   end

endmodule

// File: tb/tb_spi_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_unit: self-checking bench for spi_shift_unit (Width = 8).
// Expected frames come from a bit-serial reference model and are queued when
// a request packet completes; they are popped when the response is read.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spi_shift_unit;
   import Isa::*;

   localparam int Width  = 8;
   localparam int InLen  = in_len(Width);
   localparam int OutLen = out_len(Width);

   typedef struct packed {
      logic [Width-1:0] result;
      logic             zero;
      logic             error;
   } frame_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   int     n_checks = 0;
   int     n_fail   = 0;
   frame_t sb_q[$];

   always #5 clk = ~clk;

   Spi #(.NssWidth(1)) spi_bus ();

   spi_shift_unit #(.NssPosition(0), .Width(Width)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .spi     (spi_bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // A released line reads as Z in a 4-state simulator and as 0 in a
   // 2-state one; either shows the slave is not driving high.
   task automatic check_released(input string tag);
      check(tag, 32'(spi_bus.miso === 1'bz || spi_bus.miso === 1'b0), 32'd1);
   endtask

   function automatic frame_t model(input logic [2:0] op, input logic [Width-1:0] v, input int amt);
      frame_t f;
      f.result = v;
      f.error  = 1'b0;
      if (op > 3'd4) begin
         f.result = '0;
         f.error  = 1'b1;
         f.zero   = 1'b0;
         return f;
      end
      for (int i = 0; i < amt; i++) begin
         case (op)
            3'd0: f.result = {f.result[Width-2:0], f.result[Width-1]};
            3'd1: f.result = {f.result[0], f.result[Width-1:1]};
            3'd2: f.result = {f.result[Width-2:0], 1'b0};
            3'd3: f.result = {1'b0, f.result[Width-1:1]};
            default: f.result = {f.result[Width-1], f.result[Width-1:1]};
         endcase
      end
      f.zero = (f.result == '0);
      return f;
   endfunction

   // Sends start bit plus packet. abort_after >= 0 deselects after that many
   // packet bits; otherwise checks the OPERATE/READY latency and queues the
   // expected frame.
   task automatic send_packet(input logic [2:0] op, input logic [Width-1:0] operand,
                              input logic [2:0] amt, input int abort_after);
      logic [InLen-1:0] pkt;
      pkt = {amt, operand, op};
      @(negedge clk);
      spi_bus.nss  = 1'b0;
      spi_bus.mosi = 1'b1;
      for (int k = 0; k < InLen; k++) begin
         @(negedge clk);
         if (k == abort_after) begin
            spi_bus.nss  = 1'b1;
            spi_bus.mosi = 1'b0;
            @(negedge clk);
            check_released("abort_released");
            spi_bus.nss = 1'b0;
            @(negedge clk);
            check("abort_idle_miso", 32'(spi_bus.miso), 32'd0);
            return;
         end
         spi_bus.mosi = pkt[k];
      end
      // Last bit sampled on the next rising edge; OPERATE follows it.
      @(negedge clk);
      check("operate_miso", 32'(spi_bus.miso), 32'd0);
      spi_bus.mosi = 1'b1;
      @(negedge clk);
      check("ready_miso", 32'(spi_bus.miso), 32'd1);
      sb_q.push_back(model(op, operand, int'(amt)));
   endtask

   // Deselect while READY, then reselect with mosi=1: the result is held.
   task automatic hold_ready();
      spi_bus.nss = 1'b1;
      repeat (3) @(negedge clk);
      spi_bus.nss  = 1'b0;
      spi_bus.mosi = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("ready_hold_miso", 32'(spi_bus.miso), 32'd1);
      end
   endtask

   // Acks and reads the response frame. reset_at >= 0 pulses i_reset while
   // that output bit is on the line.
   task automatic read_frame(input int reset_at);
      frame_t            exp_f;
      logic [OutLen-1:0] bits;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      exp_f = sb_q.pop_front();
      bits  = '0;
      @(negedge clk);
      spi_bus.nss  = 1'b0;
      spi_bus.mosi = 1'b0;
      for (int k = 0; k < OutLen; k++) begin
         @(negedge clk);
         bits[k] = spi_bus.miso;
         if (k == reset_at) begin
            check("partial_bits", 32'(bits[4:0]), 32'(exp_f.result[4:0]));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("reset_idle_miso", 32'(spi_bus.miso), 32'd0);
            spi_bus.nss = 1'b1;
            @(negedge clk);
            check_released("reset_released");
            spi_bus.nss = 1'b0;
            return;
         end
      end
      check("result", 32'(bits[Width-1:0]), 32'(exp_f.result));
      check("zero",   32'(bits[Width]),     32'(exp_f.zero));
      check("error",  32'(bits[Width+1]),   32'(exp_f.error));
      @(negedge clk);
      check("idle_after_miso", 32'(spi_bus.miso), 32'd0);
   endtask

   task automatic transaction(input logic [2:0] op, input logic [Width-1:0] operand,
                              input logic [2:0] amt);
      send_packet(op, operand, amt, -1);
      read_frame(-1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      spi_bus.nss  = 1'b1;
      spi_bus.mosi = 1'b0;
      rst          = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_released("reset_released_idle");
      spi_bus.nss = 1'b0;
      @(negedge clk);
      check("reset_miso", 32'(spi_bus.miso), 32'd0);

      // ROL 0x81 by 1, with a hold/ignore period in READY.
      send_packet(3'(ROL), 8'h81, 3'd1, -1);
      hold_ready();
      read_frame(-1);

      transaction(3'(SRA), 8'h90, 3'd3);
      transaction(3'(SRL), 8'h90, 3'd3);
      transaction(3'(SLL), 8'h90, 3'd4);
      transaction(3'(ROR), 8'hA5, 3'd0);
      transaction(3'(ROR), 8'h01, 3'd7);
      transaction(3'd6,    8'hFF, 3'd0);

      // Abort after 5 packet bits; the next transaction is unaffected.
      send_packet(3'(ROL), 8'h81, 3'd1, 5);
      transaction(3'(ROL), 8'h81, 3'd1);

      // Reset while output bit 4 is on the line, then a clean transaction.
      send_packet(3'(SRA), 8'hC3, 3'd2, -1);
      read_frame(4);
      transaction(3'(SRA), 8'h90, 3'd3);

      for (int i = 0; i < 6; i++) begin
         transaction(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
